// File: rtl/issue_pkg.sv
// ============================================================================
// Module      : issue_pkg
// Description : Opcode constants, instruction classes, target masks and FSM
//               state encoding shared by the issue-stage dispatch logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_pkg;

    localparam logic [6:0] c_OP_ALU_R = 7'b0110011;
    localparam logic [6:0] c_OP_ALU_I = 7'b0010011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_LD    = 7'b0000011;
    localparam logic [6:0] c_OP_ST    = 7'b0100011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;

    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_BR    = 3'd1,
        CLS_JALR  = 3'd2,
        CLS_LD    = 3'd3,
        CLS_ST    = 3'd4,
        CLS_UPPER = 3'd5,
        CLS_JAL   = 3'd6,
        CLS_ILL   = 3'd7
    } inst_class_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FLUSH     = 2'd1,
        ST_WAIT_JALR = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic rob;
        logic rs;
        logic lsb_rs;
        logic lsb;
    } target_mask_t;

    // Every class allocates a ROB entry; only the execution resources differ.
    function automatic target_mask_t targets_of(input inst_class_e cls);
        target_mask_t m;
        m = '{rob: 1'b1, rs: 1'b0, lsb_rs: 1'b0, lsb: 1'b0};
        case (cls)
            CLS_ALU, CLS_BR, CLS_JALR: m.rs = 1'b1;
            CLS_LD, CLS_ST: begin
                m.lsb_rs = 1'b1;
                m.lsb    = 1'b1;
            end
            default: m.rs = 1'b0;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/issue_opclass_decode.sv
// ============================================================================
// Module      : issue_opclass_decode
// Description : Combinational opcode to instruction-class and target-mask map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_opclass_decode
    import issue_pkg::*;
(
    input  logic [6:0]   i_opcode,
    output inst_class_e  o_class,
    output target_mask_t o_mask
);

    inst_class_e w_class;

    always_comb begin
        w_class = CLS_ILL;
        case (i_opcode)
            c_OP_ALU_R, c_OP_ALU_I: w_class = CLS_ALU;
            c_OP_BR:                w_class = CLS_BR;
            c_OP_JALR:              w_class = CLS_JALR;
            c_OP_LD:                w_class = CLS_LD;
            c_OP_ST:                w_class = CLS_ST;
            c_OP_LUI, c_OP_AUIPC:   w_class = CLS_UPPER;
            c_OP_JAL:               w_class = CLS_JAL;
            default:                w_class = CLS_ILL;
        endcase
    end

    assign o_class = w_class;
    assign o_mask  = targets_of(w_class);

endmodule

`default_nettype wire

// File: rtl/issue_dispatch_ctrl.sv
// ============================================================================
// Module      : issue_dispatch_ctrl
// Description : Issue-stage sequencer: pops the fetch FIFO head and strobes
//               ROB / RS / LSB-RS / LSB, with flush and JALR serialization.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_dispatch_ctrl
    import issue_pkg::*;
#(
    parameter int ROB_ID_W       = 5,
    parameter int CNT_W          = 32,
    parameter int FLUSH_CYCLES   = 2,
    parameter int SERIALIZE_JALR = 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                _clear,
    input  logic                _q_empty,
    input  logic [31:0]         _q_inst,
    output logic                _q_pop,
    output logic                _q_flush,
    input  logic                _rob_full,
    input  logic [ROB_ID_W-1:0] _rob_tail_id,
    input  logic                _rs_full,
    input  logic                _lsb_rs_full,
    input  logic                _lsb_full,
    input  logic                _jalr_done,
    output logic                _rob_ready,
    output logic                _rs_ready,
    output logic                _lsb_rs_ready,
    output logic                _lsb_ready,
    output logic [2:0]          _disp_class,
    output logic [ROB_ID_W-1:0] _disp_rob_id,
    output logic [31:0]         _disp_inst,
    output logic [CNT_W-1:0]    _issued_cnt,
    output logic [CNT_W-1:0]    _stall_cnt
);

    localparam int c_TMR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    issue_state_e        r_state;
    issue_state_e        w_state_nxt;
    logic [c_TMR_W-1:0]  r_flush_tmr;
    logic [c_TMR_W-1:0]  w_flush_tmr_nxt;

    inst_class_e         w_class;
    target_mask_t        w_mask;
    logic                w_targets_free;
    logic                w_can_go;
    logic                w_stall;

    target_mask_t        r_strobe;
    logic                r_q_flush;
    inst_class_e         r_disp_class;
    logic [ROB_ID_W-1:0] r_disp_rob_id;
    logic [31:0]         r_disp_inst;
    logic [CNT_W-1:0]    r_issued_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;

    issue_opclass_decode u_decode (
        .i_opcode (_q_inst[6:0]),
        .o_class  (w_class),
        .o_mask   (w_mask)
    );

    assign w_targets_free = (!w_mask.rob    || !_rob_full)
                         && (!w_mask.rs     || !_rs_full)
                         && (!w_mask.lsb_rs || !_lsb_rs_full)
                         && (!w_mask.lsb    || !_lsb_full);

    // rst_in is folded in so the combinational pop is also quiet during reset.
    assign w_can_go = rst_in && !_q_empty && w_targets_free && (r_state == ST_IDLE)
                   && rdy_in && !_clear;

    assign w_stall  = !_q_empty && (r_state == ST_IDLE) && rdy_in && !_clear && !w_can_go;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_tmr_nxt = r_flush_tmr;
        if (rdy_in) begin
            if (_clear) begin
                w_state_nxt     = ST_FLUSH;
                w_flush_tmr_nxt = c_TMR_W'(FLUSH_CYCLES - 1);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_can_go && (w_class == CLS_JALR) && (SERIALIZE_JALR != 0))
                            w_state_nxt = ST_WAIT_JALR;
                    end
                    ST_FLUSH: begin
                        if (r_flush_tmr == '0)
                            w_state_nxt = ST_IDLE;
                        else
                            w_flush_tmr_nxt = r_flush_tmr - c_TMR_W'(1);
                    end
                    ST_WAIT_JALR: begin
                        if (_jalr_done)
                            w_state_nxt = ST_IDLE;
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= ST_IDLE;
            r_flush_tmr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_tmr <= w_flush_tmr_nxt;
        end
    end

    // w_can_go already excludes pause and clear, so strobes drop in those cycles.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_strobe      <= '0;
            r_q_flush     <= 1'b0;
            r_disp_class  <= CLS_ALU;
            r_disp_rob_id <= '0;
            r_disp_inst   <= '0;
            r_issued_cnt  <= '0;
            r_stall_cnt   <= '0;
        end else begin
            r_strobe  <= w_can_go ? w_mask : '0;
            r_q_flush <= rdy_in && _clear;
            if (w_can_go) begin
                r_disp_class  <= w_class;
                r_disp_rob_id <= _rob_tail_id;
                r_disp_inst   <= _q_inst;
                r_issued_cnt  <= r_issued_cnt + CNT_W'(1);
            end
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign _q_pop        = w_can_go;
    assign _q_flush      = r_q_flush;
    assign _rob_ready    = r_strobe.rob;
    assign _rs_ready     = r_strobe.rs;
    assign _lsb_rs_ready = r_strobe.lsb_rs;
    assign _lsb_ready    = r_strobe.lsb;
    assign _disp_class   = r_disp_class;
    assign _disp_rob_id  = r_disp_rob_id;
    assign _disp_inst    = r_disp_inst;
    assign _issued_cnt   = r_issued_cnt;
    assign _stall_cnt    = r_stall_cnt;

endmodule

`default_nettype wire
